// File: rtl/sram_arbiter.sv
// Two-requester SRAM arbiter: SPI engine and Coco front end share one 8-bit bus.
// Each access is a fixed-length timed cycle; SPI-first priority with alternation.
module sram_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int SRAM_AW       = 18,
    parameter int ACCESS_CYCLES = 6,
    parameter int CNT_W         = 3
) (
    input  logic               clock_50,
    input  logic               reset_n,
    input  logic               spi_req,
    input  logic               spi_we,
    input  logic [ADDR_W-1:0]  spi_addr,
    input  logic [7:0]         spi_wdata,
    output logic               spi_ack,
    output logic [7:0]         spi_rdata,
    input  logic               coco_req,
    input  logic               coco_we,
    input  logic [ADDR_W-1:0]  coco_addr,
    input  logic [7:0]         coco_wdata,
    output logic               coco_ack,
    output logic [7:0]         coco_rdata,
    output logic [SRAM_AW-1:0] sram_addrbus,
    input  logic [7:0]         sram_din,
    output logic [7:0]         sram_dout,
    output logic               sram_dout_en,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               actor,
    output logic               busy,
    output logic               spi_ovr,
    output logic               coco_ovr
);

    localparam int PAD_W = SRAM_AW - ADDR_W;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               spi_pend_q, coco_pend_q;
    logic               spi_we_q, coco_we_q;
    logic [ADDR_W-1:0]  spi_addr_q, coco_addr_q;
    logic [7:0]         spi_wdata_q, coco_wdata_q;
    logic               spi_ack_q, coco_ack_q;
    logic [7:0]         spi_rdata_q, coco_rdata_q;
    logic               spi_ovr_q, coco_ovr_q;
    logic               last_spi_q;
    logic               actor_q;
    logic [SRAM_AW-1:0] addr_q;
    logic [7:0]         dout_q;
    logic               we_n_q;
    logic               grant_spi_d, grant_coco_d;

    // Both pending: the requester that did not win last time goes first.
    always_comb begin
        grant_spi_d  = 1'b0;
        grant_coco_d = 1'b0;
        if (state_q == IDLE) begin
            if (spi_pend_q && coco_pend_q) begin
                grant_spi_d  = ~last_spi_q;
                grant_coco_d = last_spi_q;
            end else begin
                grant_spi_d  = spi_pend_q;
                grant_coco_d = coco_pend_q;
            end
        end
    end

    always_ff @(posedge clock_50) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            spi_pend_q   <= 1'b0;
            coco_pend_q  <= 1'b0;
            spi_we_q     <= 1'b0;
            coco_we_q    <= 1'b0;
            spi_addr_q   <= '0;
            coco_addr_q  <= '0;
            spi_wdata_q  <= 8'h00;
            coco_wdata_q <= 8'h00;
            spi_ack_q    <= 1'b0;
            coco_ack_q   <= 1'b0;
            spi_rdata_q  <= 8'h00;
            coco_rdata_q <= 8'h00;
            spi_ovr_q    <= 1'b0;
            coco_ovr_q   <= 1'b0;
            last_spi_q   <= 1'b0;
            actor_q      <= 1'b0;
            addr_q       <= '0;
            dout_q       <= 8'h00;
            we_n_q       <= 1'b1;
        end else begin
            spi_ack_q  <= 1'b0;
            coco_ack_q <= 1'b0;

            // A new request on the grant edge wins over the clear.
            if (spi_req) begin
                if (spi_pend_q && !grant_spi_d) begin
                    spi_ovr_q <= 1'b1;
                end else begin
                    spi_pend_q  <= 1'b1;
                    spi_we_q    <= spi_we;
                    spi_addr_q  <= spi_addr;
                    spi_wdata_q <= spi_wdata;
                end
            end else if (grant_spi_d) begin
                spi_pend_q <= 1'b0;
            end

            if (coco_req) begin
                if (coco_pend_q && !grant_coco_d) begin
                    coco_ovr_q <= 1'b1;
                end else begin
                    coco_pend_q  <= 1'b1;
                    coco_we_q    <= coco_we;
                    coco_addr_q  <= coco_addr;
                    coco_wdata_q <= coco_wdata;
                end
            end else if (grant_coco_d) begin
                coco_pend_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (grant_spi_d || grant_coco_d) begin
                        state_q    <= ACCESS;
                        cnt_q      <= CNT_LOAD;
                        actor_q    <= grant_spi_d;
                        last_spi_q <= grant_spi_d;
                        if (grant_spi_d) begin
                            addr_q <= {{PAD_W{1'b0}}, spi_addr_q};
                            we_n_q <= ~spi_we_q;
                            dout_q <= spi_wdata_q;
                        end else begin
                            addr_q <= {{PAD_W{1'b0}}, coco_addr_q};
                            we_n_q <= ~coco_we_q;
                            dout_q <= coco_wdata_q;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == CNT_ONE) begin
                        state_q <= IDLE;
                        we_n_q  <= 1'b1;
                        if (actor_q) begin
                            spi_ack_q <= 1'b1;
                            if (we_n_q) spi_rdata_q <= sram_din;
                        end else begin
                            coco_ack_q <= 1'b1;
                            if (we_n_q) coco_rdata_q <= sram_din;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign spi_ack      = spi_ack_q;
    assign spi_rdata    = spi_rdata_q;
    assign coco_ack     = coco_ack_q;
    assign coco_rdata   = coco_rdata_q;
    assign sram_addrbus = addr_q;
    assign sram_dout    = dout_q;
    assign sram_we_n    = we_n_q;
    assign sram_oe_n    = ~we_n_q;
    assign sram_dout_en = ~we_n_q;
    assign actor        = actor_q;
    assign busy         = (state_q == ACCESS);
    assign spi_ovr      = spi_ovr_q;
    assign coco_ovr     = coco_ovr_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed and random-stream bench for sram_arbiter with a behavioural SRAM.
// Edges are numbered from the edge that samples the request (edge 1).
module tb_sram_arbiter;

    logic        clock_50;
    logic        reset_n;
    logic        spi_req, spi_we;
    logic [15:0] spi_addr;
    logic [7:0]  spi_wdata;
    logic        spi_ack;
    logic [7:0]  spi_rdata;
    logic        coco_req, coco_we;
    logic [15:0] coco_addr;
    logic [7:0]  coco_wdata;
    logic        coco_ack;
    logic [7:0]  coco_rdata;
    logic [17:0] sram_addrbus;
    logic [7:0]  sram_din;
    logic [7:0]  sram_dout;
    logic        sram_dout_en, sram_we_n, sram_oe_n;
    logic        actor, busy, spi_ovr, coco_ovr;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] mem [0:65535];

    sram_arbiter dut (
        .clock_50(clock_50), .reset_n(reset_n),
        .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr),
        .spi_wdata(spi_wdata), .spi_ack(spi_ack), .spi_rdata(spi_rdata),
        .coco_req(coco_req), .coco_we(coco_we), .coco_addr(coco_addr),
        .coco_wdata(coco_wdata), .coco_ack(coco_ack), .coco_rdata(coco_rdata),
        .sram_addrbus(sram_addrbus), .sram_din(sram_din), .sram_dout(sram_dout),
        .sram_dout_en(sram_dout_en), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .actor(actor), .busy(busy), .spi_ovr(spi_ovr), .coco_ovr(coco_ovr)
    );

    initial clock_50 = 1'b0;
    always #5 clock_50 = ~clock_50;

    assign sram_din = mem[sram_addrbus[15:0]];
    always @(posedge clock_50) if (sram_we_n === 1'b0) mem[sram_addrbus[15:0]] <= sram_dout;

    task automatic tick();
        @(posedge clock_50);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_pair(output int sg, output int sa, output int cg, output int ca);
        sg = 0; sa = 0; cg = 0; ca = 0;
        for (int e = 2; e <= 24; e++) begin
            tick();
            if (busy && actor && sg == 0) sg = e;
            if (busy && !actor && cg == 0) cg = e;
            if (spi_ack && sa == 0) sa = e;
            if (coco_ack && ca == 0) ca = e;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle(2);
        n_cmp++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL rst_we_n got %b want 1", sram_we_n); end
        n_cmp++; if (sram_oe_n !== 1'b0 || sram_dout_en !== 1'b0) begin n_fail++; $display("FAIL rst_oe_en got %b%b want 00", sram_oe_n, sram_dout_en); end
        n_cmp++; if (sram_addrbus !== 18'h0) begin n_fail++; $display("FAIL rst_addr got %h want 0", sram_addrbus); end
        n_cmp++; if ({actor, busy, spi_ack, coco_ack} !== 4'b0) begin n_fail++; $display("FAIL rst_ctl got %b want 0000", {actor, busy, spi_ack, coco_ack}); end
        n_cmp++; if ({spi_rdata, coco_rdata} !== 16'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0000", {spi_rdata, coco_rdata}); end
        n_cmp++; if ({spi_ovr, coco_ovr} !== 2'b0) begin n_fail++; $display("FAIL rst_ovr got %b want 00", {spi_ovr, coco_ovr}); end
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_spi_write();
        int low, ack_e, ack_n;
        spi_we = 1'b1; spi_addr = 16'h1234; spi_wdata = 8'hA5; spi_req = 1'b1;
        tick();
        spi_req = 1'b0;
        tick();
        n_cmp++; if (sram_addrbus !== 18'h01234) begin n_fail++; $display("FAIL wr_addr got %h want 01234", sram_addrbus); end
        n_cmp++; if ({busy, actor, sram_we_n, sram_dout_en, sram_oe_n} !== 5'b11011) begin n_fail++; $display("FAIL wr_ctl got %b want 11011", {busy, actor, sram_we_n, sram_dout_en, sram_oe_n}); end
        n_cmp++; if (sram_dout !== 8'hA5) begin n_fail++; $display("FAIL wr_dout got %h want a5", sram_dout); end
        low = 1; ack_e = 0; ack_n = 0;
        for (int e = 3; e <= 14; e++) begin
            tick();
            if (!sram_we_n) low++;
            if (spi_ack) begin ack_n++; if (ack_e == 0) ack_e = e; end
        end
        n_cmp++; if (low !== 6) begin n_fail++; $display("FAIL wr_we_low got %0d want 6", low); end
        n_cmp++; if (ack_e !== 8) begin n_fail++; $display("FAIL wr_ack_edge got %0d want 8", ack_e); end
        n_cmp++; if (ack_n !== 1) begin n_fail++; $display("FAIL wr_ack_width got %0d want 1", ack_n); end
        n_cmp++; if (mem[16'h1234] !== 8'hA5) begin n_fail++; $display("FAIL wr_mem got %h want a5", mem[16'h1234]); end
        n_cmp++; if (actor !== 1'b1) begin n_fail++; $display("FAIL wr_actor_hold got %b want 1", actor); end
    endtask

    task automatic test_coco_read();
        int we_low, ack_e;
        logic [7:0] rd;
        mem[16'hC000] = 8'h3C;
        coco_we = 1'b0; coco_addr = 16'hC000; coco_wdata = 8'hFF; coco_req = 1'b1;
        tick();
        coco_req = 1'b0;
        we_low = 0; ack_e = 0; rd = 8'h00;
        for (int e = 2; e <= 14; e++) begin
            tick();
            if (!sram_we_n) we_low++;
            if (e == 2 && (busy !== 1'b1 || actor !== 1'b0 || sram_addrbus !== 18'h0C000)) begin
                n_fail++; $display("FAIL rd_grant got busy=%b actor=%b addr=%h want 1 0 0c000", busy, actor, sram_addrbus);
            end
            if (coco_ack && ack_e == 0) begin ack_e = e; rd = coco_rdata; end
        end
        n_cmp++;
        n_cmp++; if (we_low !== 0) begin n_fail++; $display("FAIL rd_we_low got %0d want 0", we_low); end
        n_cmp++; if (ack_e !== 8) begin n_fail++; $display("FAIL rd_ack_edge got %0d want 8", ack_e); end
        n_cmp++; if (rd !== 8'h3C) begin n_fail++; $display("FAIL rd_data got %h want 3c", rd); end
        n_cmp++; if (spi_rdata !== 8'h00) begin n_fail++; $display("FAIL rd_spi_rdata got %h want 00", spi_rdata); end
    endtask

    task automatic test_alternate();
        int sg, sa, cg, ca;
        spi_we = 1'b1; spi_addr = 16'h0010; spi_wdata = 8'h11; spi_req = 1'b1;
        coco_we = 1'b1; coco_addr = 16'h0020; coco_wdata = 8'h22; coco_req = 1'b1;
        tick();
        spi_req = 1'b0; coco_req = 1'b0;
        run_pair(sg, sa, cg, ca);
        n_cmp++; if ({sg, sa, cg, ca} !== {32'd2, 32'd8, 32'd9, 32'd15}) begin n_fail++; $display("FAIL alt1_edges got %0d %0d %0d %0d want 2 8 9 15", sg, sa, cg, ca); end
        spi_we = 1'b1; spi_addr = 16'h0030; spi_wdata = 8'h33; spi_req = 1'b1;
        tick();
        spi_req = 1'b0;
        idle(10);
        spi_we = 1'b0; spi_addr = 16'h0010; spi_req = 1'b1;
        coco_we = 1'b0; coco_addr = 16'h0020; coco_req = 1'b1;
        tick();
        spi_req = 1'b0; coco_req = 1'b0;
        run_pair(sg, sa, cg, ca);
        n_cmp++; if ({cg, ca, sg, sa} !== {32'd2, 32'd8, 32'd9, 32'd15}) begin n_fail++; $display("FAIL alt2_edges got %0d %0d %0d %0d want 2 8 9 15", cg, ca, sg, sa); end
        n_cmp++; if (spi_rdata !== 8'h11) begin n_fail++; $display("FAIL alt2_spi_rdata got %h want 11", spi_rdata); end
        n_cmp++; if (coco_rdata !== 8'h22) begin n_fail++; $display("FAIL alt2_coco_rdata got %h want 22", coco_rdata); end
    endtask

    task automatic test_overrun();
        int sg, sa, na;
        logic [17:0] ga;
        mem[16'h0300] = 8'hEE;
        coco_we = 1'b0; coco_addr = 16'hC000; coco_req = 1'b1;
        tick();
        coco_req = 1'b0;
        tick();
        spi_we = 1'b1; spi_addr = 16'h0200; spi_wdata = 8'h55; spi_req = 1'b1;
        tick();
        spi_addr = 16'h0300; spi_wdata = 8'h66;
        tick();
        spi_req = 1'b0;
        n_cmp++; if ({spi_ovr, coco_ovr} !== 2'b10) begin n_fail++; $display("FAIL ovr_flags got %b want 10", {spi_ovr, coco_ovr}); end
        sg = 0; sa = 0; ga = '0;
        for (int e = 5; e <= 24; e++) begin
            tick();
            if (busy && actor && sg == 0) begin sg = e; ga = sram_addrbus; end
            if (spi_ack) begin sa = e; break; end
        end
        n_cmp++; if ({sg, sa} !== {32'd9, 32'd15}) begin n_fail++; $display("FAIL ovr_edges got %0d %0d want 9 15", sg, sa); end
        n_cmp++; if (ga !== 18'h00200) begin n_fail++; $display("FAIL ovr_addr got %h want 00200", ga); end
        spi_addr = 16'h0400; spi_wdata = 8'h99; spi_req = 1'b1;
        tick();
        spi_req = 1'b0;
        tick();
        n_cmp++; if ({busy, actor, sram_addrbus} !== {2'b11, 18'h00400}) begin n_fail++; $display("FAIL ack_req_grant got %b%b %h want 11 00400", busy, actor, sram_addrbus); end
        na = 0;
        for (int e = 0; e < 10; e++) begin tick(); if (spi_ack) na++; end
        n_cmp++; if (na !== 1) begin n_fail++; $display("FAIL ack_req_acks got %0d want 1", na); end
        n_cmp++; if ({mem[16'h0200], mem[16'h0300], mem[16'h0400]} !== 24'h55EE99) begin n_fail++; $display("FAIL ovr_mem got %h want 55ee99", {mem[16'h0200], mem[16'h0300], mem[16'h0400]}); end
        n_cmp++; if ({spi_ovr, coco_ovr} !== 2'b10) begin n_fail++; $display("FAIL ovr_sticky got %b want 10", {spi_ovr, coco_ovr}); end
    endtask

    task automatic test_reset_mid();
        int bad;
        spi_we = 1'b1; spi_addr = 16'h0500; spi_wdata = 8'hAB; spi_req = 1'b1;
        tick();
        spi_req = 1'b0;
        tick();
        coco_we = 1'b0; coco_addr = 16'h0600; coco_req = 1'b1;
        tick();
        coco_req = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        n_cmp++; if ({sram_we_n, busy, spi_ack, coco_ack} !== 4'b1000) begin n_fail++; $display("FAIL mid_rst_ctl got %b want 1000", {sram_we_n, busy, spi_ack, coco_ack}); end
        n_cmp++; if ({spi_rdata, coco_rdata} !== 16'h0) begin n_fail++; $display("FAIL mid_rst_rdata got %h want 0000", {spi_rdata, coco_rdata}); end
        n_cmp++; if ({spi_ovr, coco_ovr, actor, sram_addrbus} !== 21'h0) begin n_fail++; $display("FAIL mid_rst_state got %b%b%b %h want 000 00000", spi_ovr, coco_ovr, actor, sram_addrbus); end
        reset_n = 1'b1;
        bad = 0;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (busy || spi_ack || coco_ack || !sram_we_n) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL mid_rst_pending got %0d active cycles want 0", bad); end
    endtask

    task automatic test_random();
        logic [7:0] ref_mem [0:15];
        logic s_out, c_out, s_w, c_w;
        logic [3:0] s_i, c_i;
        logic [7:0] s_d, c_d;
        logic [17:0] prev_addr;
        logic prev_busy;
        int run, b_ack, b_rd, b_addr, b_run, s_iss, s_ack, c_iss, c_ack;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 8'h00;
            mem[{8'h80, 4'(i), 4'h0}] = 8'h00;
        end
        s_out = 0; c_out = 0; s_w = 0; c_w = 0; s_i = 0; c_i = 0; s_d = 0; c_d = 0;
        run = 0; b_ack = 0; b_rd = 0; b_addr = 0; b_run = 0;
        s_iss = 0; s_ack = 0; c_iss = 0; c_ack = 0;
        prev_addr = sram_addrbus; prev_busy = busy;
        for (int c = 0; c < 10000; c++) begin
            tick();
            if (sram_addrbus !== prev_addr && !(busy && !prev_busy)) b_addr++;
            if (!sram_we_n) run++;
            else begin if (run != 0 && run != 6) b_run++; run = 0; end
            prev_addr = sram_addrbus; prev_busy = busy;
            if (spi_ack) begin
                s_ack++;
                if (!s_out) b_ack++;
                else if (s_w) ref_mem[s_i] = s_d;
                else if (spi_rdata !== ref_mem[s_i]) b_rd++;
                s_out = 0;
            end
            if (coco_ack) begin
                c_ack++;
                if (!c_out) b_ack++;
                else if (c_w) ref_mem[c_i] = c_d;
                else if (coco_rdata !== ref_mem[c_i]) b_rd++;
                c_out = 0;
            end
            spi_req = 1'b0; coco_req = 1'b0;
            if (c < 9970 && !s_out && $urandom_range(0, 3) == 0) begin
                s_out = 1; s_iss++;
                s_w = 1'($urandom_range(0, 1)); s_i = 4'($urandom); s_d = 8'($urandom);
                spi_req = 1'b1; spi_we = s_w; spi_addr = {8'h80, s_i, 4'h0}; spi_wdata = s_d;
            end
            if (c < 9970 && !c_out && $urandom_range(0, 3) == 0) begin
                c_out = 1; c_iss++;
                c_w = 1'($urandom_range(0, 1)); c_i = 4'($urandom); c_d = 8'($urandom);
                coco_req = 1'b1; coco_we = c_w; coco_addr = {8'h80, c_i, 4'h0}; coco_wdata = c_d;
            end
        end
        n_cmp++; if (s_iss !== s_ack || c_iss !== c_ack) begin n_fail++; $display("FAIL rnd_acks got %0d/%0d %0d/%0d want equal", s_ack, s_iss, c_ack, c_iss); end
        n_cmp++; if (b_ack !== 0) begin n_fail++; $display("FAIL rnd_spurious_ack got %0d want 0", b_ack); end
        n_cmp++; if (b_rd !== 0) begin n_fail++; $display("FAIL rnd_rdata got %0d bad want 0", b_rd); end
        n_cmp++; if (b_addr !== 0) begin n_fail++; $display("FAIL rnd_addr_stable got %0d bad want 0", b_addr); end
        n_cmp++; if (b_run !== 0) begin n_fail++; $display("FAIL rnd_we_run got %0d bad want 0", b_run); end
        n_cmp++; if ({spi_ovr, coco_ovr} !== 2'b00) begin n_fail++; $display("FAIL rnd_ovr got %b want 00", {spi_ovr, coco_ovr}); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        reset_n = 1'b0;
        spi_req = 1'b0; spi_we = 1'b0; spi_addr = 16'h0; spi_wdata = 8'h0;
        coco_req = 1'b0; coco_we = 1'b0; coco_addr = 16'h0; coco_wdata = 8'h0;
        test_reset();
        test_spi_write();
        test_coco_read();
        test_alternate();
        test_overrun();
        test_reset_mid();
        test_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
